frame_capture: RTL and testbench

- Writer side of the frame buffer. The display pipeline reads RGB565 pixels from the 400x300 block RAM; this block fills that RAM from an 8-bit DVP-style camera byte stream.
- Assembles byte pairs into RGB565 pixels and writes them at linear addresses row*H_ACTIVE+col.
- Checks frame geometry and reports line and frame errors.
- Runs single-shot or continuous, under control of the edge-mode top level.

---
 rtl/frame_capture_pkg.sv | 30 +++
 rtl/frame_capture_byte_pair_packer.sv | 58 +++++
 rtl/frame_capture.sv | 193 +++++++++++++++++++
 tb/tb_frame_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// frame_capture_pkg
//   Shared definitions for the frame-buffer writer: FSM state encoding,
//   default frame geometry, counter widths and the RGB565 pixel layout that
//   the display read path also uses.
// -----------------------------------------------------------------------------
package frame_capture_pkg;

   // FSM encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SYNC    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Default geometry of the 400x300 frame buffer
   localparam int H_ACTIVE_DEF = 400;
   localparam int V_ACTIVE_DEF = 300;
   localparam int ADDR_W_DEF   = 17;

   // Column / row counters saturate at 2^CNT_W-1
   localparam int CNT_W = 11;

   // RGB565 layout: r in [15:11], g in [10:5], b in [4:0]
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

endpackage

// File: rtl/frame_capture_byte_pair_packer.sv
// -----------------------------------------------------------------------------
// frame_capture_byte_pair_packer
//   Pairs camera bytes into RGB565 pixels. The first byte of a pair is the
//   high byte and is latched; the second byte completes the pixel, which is
//   presented combinationally together with pix_vld.
//
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : force phase back to 0 (line close, frame end, not capturing)
//   byte_en   : a qualified byte is present on data this cycle
//   data      : camera byte
//   phase     : 1 when a high byte is held and waiting for its partner
//   pix_vld   : the current byte completes a pixel
//   pix       : {held high byte, data}
// -----------------------------------------------------------------------------
module frame_capture_byte_pair_packer
   import frame_capture_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       byte_en,
   input  logic [7:0] data,
   output logic       phase,
   output logic       pix_vld,
   output rgb565_t    pix
);

   logic       phase_q, phase_d;
   logic [7:0] hi_q, hi_d;

   always_comb begin
      phase_d = phase_q;
      hi_d    = hi_q;
      // A byte arriving together with clr (frame end) still completes its
      // pixel through pix_vld; clr only resets the pairing afterwards.
      if (clr) begin
         phase_d = 1'b0;
      end else if (byte_en) begin
         phase_d = ~phase_q;
         if (!phase_q) hi_d = data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= 1'b0;
         hi_q    <= 8'd0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
      end
   end

   assign phase   = phase_q;
   assign pix_vld = byte_en & phase_q;
   assign pix     = {hi_q, data};

endmodule

// File: rtl/frame_capture.sv
// -----------------------------------------------------------------------------
// frame_capture
//   Fills the RGB565 frame buffer from an 8-bit DVP-style camera stream.
//   Byte pairs become pixels written at row*H_ACTIVE+col (computed by
//   accumulating H_ACTIVE per line, no multiplier). Checks line length and
//   frame height, single-shot or continuous capture.
//   H_ACTIVE*V_ACTIVE must not exceed 2^ADDR_W.
//
//   clk, rst      : clock, asynchronous active-low reset
//   start         : pulse, arms a capture from IDLE or DONE
//   continuous    : recapture every frame (sampled at frame end)
//   vsync, href   : frame / line sync from the camera
//   byte_valid    : byte qualifier (together with href)
//   data          : camera byte, high byte of a pixel first
//   we/waddr/wdata: RAM write port, one cycle per stored pixel
//   busy          : high in SYNC and CAPTURE
//   frame_done    : one-cycle pulse per completed frame
//   line_err      : sticky, a line had a pixel count != H_ACTIVE
//   frame_err     : sticky, a frame had a line count != V_ACTIVE
//   frame_cnt     : completed frames, wrapping
// -----------------------------------------------------------------------------
module frame_capture
   import frame_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              continuous,
   input  logic              vsync,
   input  logic              href,
   input  logic              byte_valid,
   input  logic [7:0]        data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [15:0]       wdata,
   output logic              busy,
   output logic              frame_done,
   output logic              line_err,
   output logic              frame_err,
   output logic [7:0]        frame_cnt
);

   localparam logic [CNT_W-1:0]  H_CNT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]  V_CNT  = CNT_W'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_ACTIVE);

   logic [1:0]        state_q, state_d;
   logic              vsync_q, href_q;
   logic [CNT_W-1:0]  col_q, col_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              frame_done_q, frame_done_d;
   logic              line_err_q, line_err_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;

   logic              vs_rise, href_fall, cap, line_close, frame_end;
   logic              phase, pix_vld;
   rgb565_t           pix;
   logic [CNT_W-1:0]  row_n;

   assign vs_rise   = vsync & ~vsync_q;
   assign href_fall = ~href & href_q;
   assign cap       = (state_q == ST_CAPTURE);
   // An empty line (no bytes at all) produces no line close.
   assign line_close = cap & href_fall & ((col_q != '0) | phase);
   assign frame_end  = cap & vs_rise;

   frame_capture_byte_pair_packer u_packer (
      .clk     (clk),
      .rst     (rst),
      .clr     (~cap | line_close | frame_end),
      .byte_en (cap & href & byte_valid),
      .data    (data),
      .phase   (phase),
      .pix_vld (pix_vld),
      .pix     (pix)
   );

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      base_d       = base_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      frame_done_d = 1'b0;
      line_err_d   = line_err_q;
      frame_err_d  = frame_err_q;
      frame_cnt_d  = frame_cnt_q;
      row_n        = row_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SYNC;
               line_err_d  = 1'b0;
               frame_err_d = 1'b0;
               col_d       = '0;
               row_d       = '0;
               base_d      = '0;
            end
         end

         ST_SYNC: begin
            if (vs_rise) state_d = ST_CAPTURE;
         end

         default: begin // ST_CAPTURE
            if (pix_vld) begin
               // Pixels past the active window are counted but never written.
               if (col_q < H_CNT && row_q < V_CNT) begin
                  we_d    = 1'b1;
                  waddr_d = base_q + ADDR_W'(col_q);
                  wdata_d = pix;
               end
               if (col_q != '1) col_d = col_q + 1'b1;
            end

            if (line_close) begin
               if (col_q != H_CNT || phase) line_err_d = 1'b1;
               // row keeps counting past V_ACTIVE so extra lines show up as
               // frame_err; base stops so it never points past the buffer.
               if (row_q != '1) row_n = row_q + 1'b1;
               if (row_q < V_CNT) base_d = base_q + H_ADDR;
               row_d = row_n;
               col_d = '0;
            end

            // Frame end sees the row count including a line closed this cycle.
            if (vs_rise) begin
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 8'd1;
               if (row_n != V_CNT) frame_err_d = 1'b1;
               row_d  = '0;
               col_d  = '0;
               base_d = '0;
               if (!continuous) state_d = ST_DONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         base_q       <= '0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         frame_done_q <= 1'b0;
         line_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync;
         href_q       <= href;
         col_q        <= col_d;
         row_q        <= row_d;
         base_q       <= base_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         frame_done_q <= frame_done_d;
         line_err_q   <= line_err_d;
         frame_err_q  <= frame_err_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign we         = we_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign busy       = (state_q == ST_SYNC) | (state_q == ST_CAPTURE);
   assign frame_done = frame_done_q;
   assign line_err   = line_err_q;
   assign frame_err  = frame_err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_capture.sv
// -----------------------------------------------------------------------------
// tb_frame_capture
//   Directed bench for frame_capture on a scaled 20x12 frame (ADDR_W=8, so the
//   last address 239 sits near the top of the address space). A line/pixel
//   model predicts every RAM write as bytes are driven; a negedge process
//   checks each write against it. Frame-level flags and a few literal
//   values are checked after each frame.
// -----------------------------------------------------------------------------
module tb_frame_capture;

   localparam int H  = 20;
   localparam int V  = 12;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    data = 8'd0;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic          busy, frame_done, line_err, frame_err;
   logic [7:0]    frame_cnt;

   frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .vsync(vsync), .href(href), .byte_valid(byte_valid), .data(data),
      .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
      .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state
   logic [AW-1:0] exp_addr[$];
   logic [15:0]   exp_data[$];
   int            m_row, m_lbytes, gbyte;
   logic [7:0]    prev;
   bit            exp_line_err, exp_frame_err;
   int            exp_cnt, exp_done;

   // observed writes
   int            wr_log[$];
   logic [15:0]   ram[0:255];
   logic [15:0]   golden[0:255];
   int            max_addr;
   int            done_pulses = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : compare
      logic [AW-1:0] ea;
      logic [15:0]   ed;
      if (rst) begin
         if (frame_done) done_pulses++;
         if (we) begin
            wr_log.push_back(int'(waddr));
            ram[waddr] = wdata;
            if (int'(waddr) > max_addr) max_addr = int'(waddr);
            if (exp_addr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data %h expected none", waddr, wdata);
            end else begin
               ea = exp_addr.pop_front();
               ed = exp_data.pop_front();
               chk("waddr", waddr, ea);
               chk("wdata", wdata, ed);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      exp_line_err  = 1'b0;
      exp_frame_err = 1'b0;
      wr_log.delete();
      max_addr = -1;
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      cyc();
      cyc();
      vsync = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic begin_frame();
      vs_pulse();
      m_row = 0; m_lbytes = 0; gbyte = 0;
   endtask

   task automatic end_frame();
      if (m_row != V) exp_frame_err = 1'b1;
      exp_cnt++;
      exp_done++;
      vs_pulse();
      m_row = 0; m_lbytes = 0; gbyte = 0;
   endtask

   // Pixel p of a line is bytes 2p (high) and 2p+1 (low); stored only inside
   // the H x V window at row*H+p.
   task automatic send_bytes(input int n, input bit gaps);
      int p;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               href = 1'b1; byte_valid = 1'b0; data = 8'($urandom);
               cyc();
            end
         end
         start = (gaps && m_row == 3 && i == 5);
         href = 1'b1; byte_valid = 1'b1; data = 8'(gbyte);
         if (m_lbytes % 2 == 1) begin
            p = m_lbytes / 2;
            if (p < H && m_row < V) begin
               exp_addr.push_back(AW'(m_row * H + p));
               exp_data.push_back({prev, data});
            end
         end
         prev = data;
         m_lbytes++;
         gbyte++;
         cyc();
         start = 1'b0;
      end
      byte_valid = 1'b0;
   endtask

   task automatic close_line();
      href = 1'b0; byte_valid = 1'b0;
      if (m_lbytes > 0) begin
         m_row++;
         if (m_lbytes != 2 * H) exp_line_err = 1'b1;
      end
      m_lbytes = 0;
      cyc();
      cyc();
   endtask

   task automatic send_lines(input int nlines, input int len, input bit gaps);
      for (int l = 0; l < nlines; l++) begin
         send_bytes(len, gaps);
         close_line();
      end
   endtask

   task automatic frame_checks(input string nm, input bit exp_busy);
      cyc();
      chk({nm, ":frame_cnt"}, frame_cnt, exp_cnt % 256);
      chk({nm, ":done_pulses"}, done_pulses, exp_done);
      chk({nm, ":line_err"}, line_err, exp_line_err);
      chk({nm, ":frame_err"}, frame_err, exp_frame_err);
      chk({nm, ":busy"}, busy, exp_busy);
      chk({nm, ":pending_writes"}, exp_addr.size(), 0);
   endtask

   initial begin
      exp_cnt = 0; exp_done = 0; m_row = 0; m_lbytes = 0; gbyte = 0; prev = 8'd0;
      max_addr = -1;
      for (int a = 0; a < 256; a++) ram[a] = 16'd0;

      // reset state
      #1;
      chk("rst:we", we, 0);
      chk("rst:waddr", waddr, 0);
      chk("rst:wdata", wdata, 0);
      chk("rst:busy", busy, 0);
      chk("rst:frame_done", frame_done, 0);
      chk("rst:errs", {line_err, frame_err}, 0);
      chk("rst:frame_cnt", frame_cnt, 0);
      cyc(); cyc();
      rst = 1'b1;
      cyc();

      // nominal single-shot frame
      do_start();
      chk("nom:busy_sync", busy, 1);
      begin_frame();
      send_lines(V, 2 * H, 1'b0);
      end_frame();
      frame_checks("nom", 1'b0);
      chk("nom:writes", wr_log.size(), H * V);
      chk("nom:first_addr", wr_log[0], 0);
      chk("nom:first_data", ram[0], 16'h0001);
      chk("nom:last_addr", wr_log[wr_log.size() - 1], H * V - 1);
      chk("nom:last_data", ram[H * V - 1], 16'hDEDF);
      golden = ram;

      // start while DONE with stray bytes is fine; long then short line
      do_start();
      begin_frame();
      send_lines(1, 2 * H + 2, 1'b0);
      send_lines(1, 2 * H - 2, 1'b0);
      send_lines(V - 2, 2 * H, 1'b0);
      end_frame();
      frame_checks("longshort", 1'b0);
      chk("longshort:writes", wr_log.size(), H + (H - 1) + (V - 2) * H);
      chk("longshort:line2_addr", wr_log[2 * H - 1], 2 * H);
      chk("longshort:line_err_lit", line_err, 1);

      // extra lines: nothing past the buffer
      do_start();
      begin_frame();
      send_lines(V + 5, 2 * H, 1'b0);
      end_frame();
      frame_checks("extra", 1'b0);
      chk("extra:max_addr", max_addr, H * V - 1);
      chk("extra:frame_err_lit", frame_err, 1);

      // one line short
      do_start();
      begin_frame();
      send_lines(V - 1, 2 * H, 1'b0);
      end_frame();
      frame_checks("short", 1'b0);
      chk("short:frame_err_lit", frame_err, 1);

      // continuous: three frames, continuous dropped during the third
      continuous = 1'b1;
      do_start();
      begin_frame();
      send_lines(V, 2 * H, 1'b0);
      end_frame();
      frame_checks("cont1", 1'b1);
      send_lines(V, 2 * H, 1'b0);
      end_frame();
      frame_checks("cont2", 1'b1);
      send_lines(V / 2, 2 * H, 1'b0);
      continuous = 1'b0;
      send_lines(V - V / 2, 2 * H, 1'b0);
      end_frame();
      frame_checks("cont3", 1'b0);
      chk("cont:writes", wr_log.size(), 3 * H * V);

      // reset in the middle of row 5, right as a write is on the port
      do_start();
      begin_frame();
      send_lines(5, 2 * H, 1'b0);
      send_bytes(10, 1'b0);
      chk("rstmid:we_before", we, 1);
      rst = 1'b0;
      #1;
      chk("rstmid:we", we, 0);
      chk("rstmid:waddr", waddr, 0);
      chk("rstmid:wdata", wdata, 0);
      chk("rstmid:busy", busy, 0);
      chk("rstmid:flags", {frame_done, line_err, frame_err}, 0);
      chk("rstmid:frame_cnt", frame_cnt, 0);
      exp_addr.delete(); exp_data.delete();
      exp_cnt = 0;
      href = 1'b0; byte_valid = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      do_start();
      begin_frame();
      send_lines(V, 2 * H, 1'b0);
      end_frame();
      frame_checks("after_rst", 1'b0);
      chk("after_rst:first_addr", wr_log[0], 0);

      // gaps: bytes during SYNC, random byte_valid holes, start while busy
      for (int a = 0; a < 256; a++) ram[a] = 16'd0;
      do_start();
      for (int i = 0; i < 6; i++) begin
         href = 1'b1; byte_valid = 1'b1; data = 8'($urandom);
         cyc();
      end
      href = 1'b0; byte_valid = 1'b0;
      cyc(); cyc();
      chk("gaps:busy_sync", busy, 1);
      begin_frame();
      send_lines(V, 2 * H, 1'b1);
      end_frame();
      frame_checks("gaps", 1'b0);
      begin
         int mism = 0;
         for (int a = 0; a < H * V; a++) if (ram[a] !== golden[a]) mism++;
         chk("gaps:ram_vs_gapless", mism, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
